s2_burst_sink: RTL

- Downstream slave stage for the 16-bit valid/ready burst master.
- Accepts words into a small FWFT FIFO and re-presents them on a second valid/ready port toward the consumer.
- Delimits bursts by valid gaps and reports per-burst length and a burst count.
- Sequence-checks word values (1,2,3,... per burst) when the optional checker is compiled in.

---
 rtl/s2_pkg.sv | 12 +
 rtl/s2_sync_fifo.sv | 48 ++++
 rtl/s2_burst_sink.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/s2_pkg.sv
// Shared defaults and types for the s2 burst sink and its FIFO.
package s2_pkg;
  localparam int DATA_W_DEF    = 16;
  localparam int DEPTH_DEF     = 8;
  localparam int CNT_W_DEF     = 8;
  localparam int BURST_LEN_MAX = 15;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } burst_state_t;
endpackage

// File: rtl/s2_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head word is visible on o_rdata
// whenever o_empty is low. Storage is not reset, only the pointers are.
module s2_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_wdata,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_push;
  logic              w_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/s2_burst_sink.sv
// Burst sink: buffers upstream words in a FWFT FIFO, delimits bursts by valid
// gaps. Optional word-sequence checker compiled in with S2_SEQ_CHECK_EN.
module s2_burst_sink
  import s2_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              burst_done,
  output logic [3:0]        burst_len,
  output logic [CNT_W-1:0]  burst_cnt,
  output logic              seq_err,
  output logic [CNT_W-1:0]  err_cnt
);
  localparam int AW = $clog2(DEPTH);

  function automatic logic [3:0] len_sat_inc(input logic [3:0] v);
    return (v == 4'(BURST_LEN_MAX)) ? v : v + 4'd1;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [DATA_W-1:0] w_rdata;
  logic              w_full;
  logic              w_empty;
  logic [AW:0]       w_fill;
  logic              w_push;
  logic              w_pop;

  burst_state_t      r_state, w_state_nxt;
  logic [3:0]        r_wcnt, w_wcnt_nxt;
  logic              r_done, w_done_nxt;
  logic [3:0]        r_len, w_len_nxt;
  logic [CNT_W-1:0]  r_bcnt, w_bcnt_nxt;

  // ready_out is forced low while rst is asserted, independent of fill
  assign ready_out = !rst && (w_fill < (AW+1)'(DEPTH));
  assign w_push    = valid_in && ready_out && !w_full;
  assign valid_out = !w_empty;
  assign w_pop     = valid_out && ready_in;
  assign data_out  = w_empty ? '0 : w_rdata;

  s2_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (data_in),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fill)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_done  <= 1'b0;
      r_len   <= '0;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_done  <= w_done_nxt;
      r_len   <= w_len_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  // Stalled cycles with valid_in high keep the burst open
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_done_nxt  = 1'b0;
    w_len_nxt   = r_len;
    w_bcnt_nxt  = r_bcnt;
    case (r_state)
      IDLE: begin
        if (w_push) begin
          w_state_nxt = RECV;
          w_wcnt_nxt  = 4'd1;
        end
      end
      RECV: begin
        if (!valid_in) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
          w_len_nxt   = r_wcnt;
          w_bcnt_nxt  = r_bcnt + 1'b1;
        end else if (w_push) begin
          w_wcnt_nxt = len_sat_inc(r_wcnt);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign burst_done = r_done;
  assign burst_len  = r_len;
  assign burst_cnt  = r_bcnt;

`ifdef S2_SEQ_CHECK_EN
  logic [DATA_W-1:0] r_exp;
  logic [DATA_W-1:0] w_exp;
  logic              w_mis;
  logic              r_seq_err;
  logic [CNT_W-1:0]  r_err_cnt;

  // The first word of every burst is expected to be 1
  assign w_exp = (r_state == IDLE) ? DATA_W'(1) : r_exp;
  assign w_mis = w_push && (data_in != w_exp);

  always_ff @(posedge clk) begin
    if (w_push) r_exp <= w_exp + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seq_err <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_mis) begin
      r_seq_err <= 1'b1;
      r_err_cnt <= cnt_sat_inc(r_err_cnt);
    end
  end

  assign seq_err = r_seq_err;
  assign err_cnt = r_err_cnt;
`else
  assign seq_err = 1'b0;
  assign err_cnt = '0;
`endif
endmodule
